// File: rtl/cic_decim_comb.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_comb
// Brief    : CIC decimator plus STAGES-deep comb cascade for an I/Q stream.
//            Optional output rounding register enabled by CIC_COMB_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decim_comb #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16,
    parameter int DECIM     = 8,
    parameter int DELAY     = 2,
    parameter int STAGES    = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [WIDTH-1:0]     i_inph_data,
    input  logic [WIDTH-1:0]     i_quad_data,
    input  logic                 i_valid,
    output logic [OUT_WIDTH-1:0] o_inph_data,
    output logic [OUT_WIDTH-1:0] o_quad_data,
    output logic                 o_valid
);

    localparam int              c_CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DECIM - 1);

    logic [c_CW-1:0] r_count;
    logic            w_keep;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_valid) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_CW'(1);
        end
    end

    assign w_keep = i_valid && (r_count == '0);

    // Index k is the input of comb stage k; index STAGES is the final result.
    logic [WIDTH-1:0] w_x_i [STAGES+1];
    logic [WIDTH-1:0] w_x_q [STAGES+1];
    logic [STAGES:0]  w_v;

    assign w_x_i[0] = i_inph_data;
    assign w_x_q[0] = i_quad_data;
    assign w_v[0]   = w_keep;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] r_dly_i [DELAY];
        logic [WIDTH-1:0] r_dly_q [DELAY];
        logic [WIDTH-1:0] r_res_i;
        logic [WIDTH-1:0] r_res_q;
        logic             r_vld;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                for (int j = 0; j < DELAY; j++) begin
                    r_dly_i[j] <= '0;
                    r_dly_q[j] <= '0;
                end
                r_res_i <= '0;
                r_res_q <= '0;
                r_vld   <= 1'b0;
            end else begin
                r_vld <= w_v[k];
                if (w_v[k]) begin
                    r_res_i    <= w_x_i[k] - r_dly_i[DELAY-1];
                    r_res_q    <= w_x_q[k] - r_dly_q[DELAY-1];
                    r_dly_i[0] <= w_x_i[k];
                    r_dly_q[0] <= w_x_q[k];
                    for (int j = 1; j < DELAY; j++) begin
                        r_dly_i[j] <= r_dly_i[j-1];
                        r_dly_q[j] <= r_dly_q[j-1];
                    end
                end
            end
        end

        assign w_x_i[k+1] = r_res_i;
        assign w_x_q[k+1] = r_res_q;
        assign w_v[k+1]   = r_vld;
    end

`ifdef CIC_COMB_ROUND_EN
    logic [WIDTH-1:0] w_rnd_i;
    logic [WIDTH-1:0] w_rnd_q;
    logic [WIDTH-1:0] r_out_i;
    logic [WIDTH-1:0] r_out_q;
    logic             r_out_v;

    if (OUT_WIDTH < WIDTH) begin : g_round
        localparam logic [WIDTH-1:0] c_HALF = WIDTH'(1) << (WIDTH - OUT_WIDTH - 1);
        assign w_rnd_i = w_x_i[STAGES] + c_HALF;
        assign w_rnd_q = w_x_q[STAGES] + c_HALF;
    end else begin : g_pass
        assign w_rnd_i = w_x_i[STAGES];
        assign w_rnd_q = w_x_q[STAGES];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_i <= '0;
            r_out_q <= '0;
            r_out_v <= 1'b0;
        end else begin
            r_out_v <= w_v[STAGES];
            if (w_v[STAGES]) begin
                r_out_i <= w_rnd_i;
                r_out_q <= w_rnd_q;
            end
        end
    end

    assign o_inph_data = r_out_i[WIDTH-1 -: OUT_WIDTH];
    assign o_quad_data = r_out_q[WIDTH-1 -: OUT_WIDTH];
    assign o_valid     = r_out_v;

    if (OUT_WIDTH < WIDTH) begin : g_lsb
        logic w_unused_lsb;
        assign w_unused_lsb = ^{r_out_i[WIDTH-OUT_WIDTH-1:0], r_out_q[WIDTH-OUT_WIDTH-1:0]};
    end
`else
    // The last comb register holds between strobes, so it drives the outputs directly.
    assign o_inph_data = w_x_i[STAGES][WIDTH-1 -: OUT_WIDTH];
    assign o_quad_data = w_x_q[STAGES][WIDTH-1 -: OUT_WIDTH];
    assign o_valid     = w_v[STAGES];

    if (OUT_WIDTH < WIDTH) begin : g_lsb
        logic w_unused_lsb;
        assign w_unused_lsb = ^{w_x_i[STAGES][WIDTH-OUT_WIDTH-1:0],
                                w_x_q[STAGES][WIDTH-OUT_WIDTH-1:0]};
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_comb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decim_comb
// Brief    : Scoreboard bench for cic_decim_comb over four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decim_comb;

`ifdef CIC_COMB_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] i;
        logic [15:0] q;
    } exp_t;

    exp_t qa[$], qb[$], qc[$], qd[$];
    int   checks = 0;
    int   errors = 0;

    // a: R=4 N=1 | b: R=1 N=1 | c: R=1 N=2 | d: R=1 N=1 OUT_WIDTH=8
    logic        rst_a, rst_b, rst_c, rst_d;
    logic        vi_a, vi_b, vi_c, vi_d;
    logic [15:0] ii_a, ii_b, ii_c, ii_d;
    logic [15:0] qi_a, qi_b, qi_c, qi_d;
    logic [15:0] oi_a, oi_b, oi_c, oq_a, oq_b, oq_c;
    logic [7:0]  oi_d, oq_d;
    logic        ov_a, ov_b, ov_c, ov_d;

    cic_decim_comb #(.WIDTH(16), .OUT_WIDTH(16), .DECIM(4), .DELAY(1), .STAGES(1)) u_a (
        .i_clock(clk), .i_reset(rst_a), .i_inph_data(ii_a), .i_quad_data(qi_a),
        .i_valid(vi_a), .o_inph_data(oi_a), .o_quad_data(oq_a), .o_valid(ov_a));
    cic_decim_comb #(.WIDTH(16), .OUT_WIDTH(16), .DECIM(1), .DELAY(1), .STAGES(1)) u_b (
        .i_clock(clk), .i_reset(rst_b), .i_inph_data(ii_b), .i_quad_data(qi_b),
        .i_valid(vi_b), .o_inph_data(oi_b), .o_quad_data(oq_b), .o_valid(ov_b));
    cic_decim_comb #(.WIDTH(16), .OUT_WIDTH(16), .DECIM(1), .DELAY(1), .STAGES(2)) u_c (
        .i_clock(clk), .i_reset(rst_c), .i_inph_data(ii_c), .i_quad_data(qi_c),
        .i_valid(vi_c), .o_inph_data(oi_c), .o_quad_data(oq_c), .o_valid(ov_c));
    cic_decim_comb #(.WIDTH(16), .OUT_WIDTH(8), .DECIM(1), .DELAY(1), .STAGES(1)) u_d (
        .i_clock(clk), .i_reset(rst_d), .i_inph_data(ii_d), .i_quad_data(qi_d),
        .i_valid(vi_d), .o_inph_data(oi_d), .o_quad_data(oq_d), .o_valid(ov_d));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic stray(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: unexpected o_valid strobe got 1 expected 0 (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops one expectation per strobe, checking arrival cycle and data.
    always @(negedge clk) begin
        exp_t e;
        if (ov_a === 1'b1) begin
            if (qa.size() == 0) stray("a_strobe");
            else begin
                e = qa.pop_front();
                chk("a_cycle", cyc, e.cyc); chk("a_inph", oi_a, e.i); chk("a_quad", oq_a, e.q);
            end
        end
        if (ov_b === 1'b1) begin
            if (qb.size() == 0) stray("b_strobe");
            else begin
                e = qb.pop_front();
                chk("b_cycle", cyc, e.cyc); chk("b_inph", oi_b, e.i); chk("b_quad", oq_b, e.q);
            end
        end
        if (ov_c === 1'b1) begin
            if (qc.size() == 0) stray("c_strobe");
            else begin
                e = qc.pop_front();
                chk("c_cycle", cyc, e.cyc); chk("c_inph", oi_c, e.i); chk("c_quad", oq_c, e.q);
            end
        end
        if (ov_d === 1'b1) begin
            if (qd.size() == 0) stray("d_strobe");
            else begin
                e = qd.pop_front();
                chk("d_cycle", cyc, e.cyc);
                chk("d_inph", {24'd0, oi_d}, {24'd0, e.i[7:0]});
                chk("d_quad", {24'd0, oq_d}, {24'd0, e.q[7:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input int lat, input logic [15:0] ei, input logic [15:0] eq);
        exp_t e;
        e.cyc = cyc + lat + RND;
        e.i   = ei;
        e.q   = eq;
        case (inst)
            0: qa.push_back(e);
            1: qb.push_back(e);
            2: qc.push_back(e);
            default: qd.push_back(e);
        endcase
    endtask

    initial begin
        {rst_a, rst_b, rst_c, rst_d} = 4'hF;
        {vi_a, vi_b, vi_c, vi_d}     = 4'h0;
        {ii_a, ii_b, ii_c, ii_d}     = '0;
        {qi_a, qi_b, qi_c, qi_d}     = '0;
        repeat (2) step();

        chk("rst_a_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_a_inph", {16'd0, oi_a}, 32'd0);
        chk("rst_b_valid", {31'd0, ov_b}, 32'd0);
        chk("rst_b_quad", {16'd0, oq_b}, 32'd0);
        chk("rst_c_valid", {31'd0, ov_c}, 32'd0);
        chk("rst_d_valid", {31'd0, ov_d}, 32'd0);
        {rst_a, rst_b, rst_c, rst_d} = 4'h0;

        // Continuous ramp, keep every 4th: I diff 0,4,4,4; Q = 2*I gives 0,8,8,8.
        for (int k = 0; k < 16; k++) begin
            vi_a = 1'b1; ii_a = 16'(k); qi_a = 16'(2 * k);
            if (k % 4 == 0) push(0, 1, (k == 0) ? 16'h0000 : 16'h0004, (k == 0) ? 16'h0000 : 16'h0008);
            step();
        end
        vi_a = 1'b0;
        repeat (4) step();
        rst_a = 1'b1; step(); rst_a = 1'b0;

        // Gapped ramp: same values, strobes 8 cycles apart.
        for (int k = 0; k < 16; k++) begin
            vi_a = 1'b1; ii_a = 16'(k); qi_a = 16'(2 * k);
            if (k % 4 == 0) push(0, 1, (k == 0) ? 16'h0000 : 16'h0004, (k == 0) ? 16'h0000 : 16'h0008);
            step();
            vi_a = 1'b0;
            step();
        end

        // Wrap-around on Q: 0xFFF0 then 0x0010 -> 0xFFF0, 0x0020.
        vi_b = 1'b1; ii_b = 16'h0003; qi_b = 16'hFFF0;
        push(1, 1, 16'h0003, 16'hFFF0);
        step();
        ii_b = 16'h0001; qi_b = 16'h0010;
        push(1, 1, 16'hFFFE, 16'h0020);
        step();
        vi_b = 1'b0;

        // Two-stage cascade on a constant 5.
        vi_c = 1'b1; ii_c = 16'h0005; qi_c = 16'h0000;
        push(2, 2, 16'h0005, 16'h0000); step();
        push(2, 2, 16'hFFFB, 16'h0000); step();
        push(2, 2, 16'h0000, 16'h0000); step();
        vi_c = 1'b0;
        repeat (RND) step();
        // Two samples then a reset that also collides with a valid: both discarded.
        vi_c = 1'b1; ii_c = 16'h0005; step();
        rst_c = 1'b1; step();
        rst_c = 1'b0; vi_c = 1'b0;
        chk("c_post_rst_valid", {31'd0, ov_c}, 32'd0);
        chk("c_post_rst_inph", {16'd0, oi_c}, 32'd0);
        chk("c_post_rst_quad", {16'd0, oq_c}, 32'd0);
        repeat (3) step();
        vi_c = 1'b1; ii_c = 16'h0007;
        push(2, 2, 16'h0007, 16'h0000); step();
        push(2, 2, 16'hFFF9, 16'h0000); step();
        vi_c = 1'b0;

        // Rounding versus truncation to 8 bits.
        vi_d = 1'b1; ii_d = 16'h0180; qi_d = 16'h0000;
        push(3, 1, (RND != 0) ? 16'h0002 : 16'h0001, 16'h0000);
        step();
        vi_d = 1'b0;
        repeat (4) step();
        rst_d = 1'b1; step(); rst_d = 1'b0;
        vi_d = 1'b1; ii_d = 16'h7F80; qi_d = 16'h0080;
        push(3, 1, (RND != 0) ? 16'h0080 : 16'h007F, (RND != 0) ? 16'h0001 : 16'h0000);
        step();
        vi_d = 1'b0;

        repeat (12) step();
        chk("a_pending", qa.size(), 32'd0);
        chk("b_pending", qb.size(), 32'd0);
        chk("c_pending", qc.size(), 32'd0);
        chk("d_pending", qd.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_decim_comb.md
Name: cic_decim_comb

Overview:
Decimator plus comb section of the CIC decimation chain. It sits directly downstream of the I/Q integrator stage. It keeps every DECIM-th valid integrator output, then runs the kept samples through STAGES cascaded comb sections (y[n] = x[n] - x[n-DELAY], counted in decimated samples). It produces a low-rate I/Q stream with an output valid strobe for the following filter/gain stage.

Parameters:
WIDTH, 16, integrator/comb internal word width (two's complement, modulo 2^WIDTH arithmetic)
OUT_WIDTH, 16, output word width; must be <= WIDTH; output is the top OUT_WIDTH bits of the final comb result
DECIM, 8, decimation ratio R; legal range >= 1; DECIM=1 keeps every valid sample
DELAY, 2, differential delay M in decimated samples; legal range >= 1
STAGES, 3, number of cascaded comb sections N; legal range >= 1

Ports:
i_clock  input  1  clock for all logic
i_reset  input  1  reset, synchronous to i_clock, active-high
i_inph_data  input  WIDTH  in-phase integrator output
i_quad_data  input  WIDTH  quadrature integrator output
i_valid  input  1  input sample strobe; data sampled only when high
o_inph_data  output  OUT_WIDTH  in-phase decimated comb output
o_quad_data  output  OUT_WIDTH  quadrature decimated comb output
o_valid  output  1  one-cycle strobe marking a new output sample

Behaviour:
- Decimation counter: 0..DECIM-1, advances only on cycles with i_valid=1, wraps DECIM-1 -> 0. Idle cycles do not advance it.
- Sample keep: a valid cycle with counter==0 is kept. The first valid after reset is always kept, then every DECIM-th valid after it. DECIM=1 keeps every valid.
- Comb stage k (k=1..STAGES):
  - Holds a DELAY-deep shift register per rail plus one result register per rail.
  - On a kept sample arriving at stage k: result = x - x_delayed(DELAY samples back), wrapped mod 2^WIDTH. x then shifts into the delay line.
  - Delay lines shift only on stage-local valid, never on idle cycles.
- Pipeline: one register per stage, with a valid bit shifting alongside the data.
- Latency: kept sample at cycle t -> o_valid=1 at cycle t+STAGES (t+STAGES+1 with CIC_COMB_ROUND_EN).
- Throughput: one kept sample per cycle sustained, with no backpressure; o_valid is never more than 1 cycle wide per sample.
- Output (macro off): o_*_data = final result bits [WIDTH-1 : WIDTH-OUT_WIDTH] (truncation).
- o_*_data holds its last value between o_valid strobes.
- I and Q rails are processed identically and in lockstep, sharing the counter and valids.
- Reset: counter=0; all delay lines=0; all pipeline data=0; pipeline valids=0; o_valid=0; o_inph_data=0; o_quad_data=0.
  - Reset mid-stream discards in-flight samples: no o_valid on the cycle after reset.
  - The first valid after reset release is kept, and combs start from zero history.
  - Reset takes priority over i_valid in the same cycle.
- Startup: the first DELAY outputs per stage reflect zero history; this is expected, not masked.
- Overflow: none flagged; wrap-around is the required behaviour, since CIC gain is absorbed by WIDTH.

Optional Feature:
Macro CIC_COMB_ROUND_EN.
- Defined:
  - Adds one output register stage (latency +1).
  - When OUT_WIDTH < WIDTH: output = top OUT_WIDTH bits of (result + 2^(WIDTH-OUT_WIDTH-1)), i.e. round half up, wrapping mod 2^WIDTH with no saturation.
  - When OUT_WIDTH == WIDTH: passes the result unchanged, with the extra cycle of latency.
- Undefined: plain truncation; latency STAGES.

Test Plan:
1. Continuous ramp, DECIM=4, DELAY=1, STAGES=1, WIDTH=OUT_WIDTH=16: I = 0,1,2,...,15 with i_valid=1 every cycle -> kept 0,4,8,12 -> o_inph_data 0x0000,0x0004,0x0004,0x0004. Each o_valid comes 1 cycle after its kept input, and exactly 4 o_valid strobes occur.
2. Gapped valid, same config: i_valid high every other cycle with the same ramp -> identical output values. o_valid spacing is 8 cycles, with no extra strobes during gaps.
3. Wrap-around, DECIM=1, DELAY=1, STAGES=1: Q inputs 0xFFF0 then 0x0010 -> o_quad_data 0xFFF0 then 0x0020.
4. Cascade, DECIM=1, DELAY=1, STAGES=2: constant I=5 for 3 samples -> 0x0005, 0xFFFB, 0x0000. The first o_valid appears 2 cycles after the first input.
5. Reset mid-stream: assert i_reset for 1 cycle while 2 samples are in flight in test 4. Required response:
   - o_valid=0 and outputs=0 on the next cycle.
   - No stale strobe follows.
   - The next input I=7 yields 0x0007 then 0xFFF9, as from zero history.
6. Rounding, DECIM=1, DELAY=1, STAGES=1, WIDTH=16, OUT_WIDTH=8, single input 0x0180:
   - Macro off -> 0x01.
   - Macro on -> 0x02, 1 cycle later.
   - Input 0x7F80 with macro on -> 0x80.
